// File: rtl/dp_control_fsm_if.sv
// Control bus between the dp_control_fsm sequencer and the datapath.
// master: the control FSM (reads IR/MFC/COND, drives all controls).
// slave : the datapath side.
interface dp_control_fsm_if;
  logic [31:0] IR;
  logic        MFC;
  logic        COND;

  logic        IRE;
  logic        MDRE;
  logic        PCE;
  logic        nPCE;
  logic        MARE;
  logic        RFE;

  logic        ClrPC;
  logic        nPCClr;
  logic        IRClr;
  logic        tQClr;

  logic        MFA;
  logic        ALUE;
  logic        nPC_ADD;
  logic        nPC_ADDSEL;
  logic        BAUX;
  logic        MOP_SEL;
  logic        DISP_SEL;
  logic        RA_SEL;
  logic        AOP_SEL;

  logic [1:0]  nPC_SEL;
  logic [1:0]  MAR_SEL;
  logic [1:0]  MDR_SEL;
  logic [1:0]  ALU_SEL;
  logic [1:0]  CIN_SEL;
  logic [1:0]  RC_SEL;

  logic [5:0]  OP1;
  logic        FAULT;
  logic [3:0]  STATE;

  modport master (
    input  IR, MFC, COND,
    output IRE, MDRE, PCE, nPCE, MARE, RFE,
    output ClrPC, nPCClr, IRClr, tQClr,
    output MFA, ALUE, nPC_ADD, nPC_ADDSEL, BAUX, MOP_SEL, DISP_SEL, RA_SEL, AOP_SEL,
    output nPC_SEL, MAR_SEL, MDR_SEL, ALU_SEL, CIN_SEL, RC_SEL,
    output OP1, FAULT, STATE
  );

  modport slave (
    output IR, MFC, COND,
    input  IRE, MDRE, PCE, nPCE, MARE, RFE,
    input  ClrPC, nPCClr, IRClr, tQClr,
    input  MFA, ALUE, nPC_ADD, nPC_ADDSEL, BAUX, MOP_SEL, DISP_SEL, RA_SEL, AOP_SEL,
    input  nPC_SEL, MAR_SEL, MDR_SEL, ALU_SEL, CIN_SEL, RC_SEL,
    input  OP1, FAULT, STATE
  );
endinterface

// File: rtl/dp_control_fsm.sv
// Moore control sequencer for a small SPARC-like datapath:
// reset, instruction fetch with memory handshake, decode, ALU op,
// taken/annulled branch handling and PC/nPC update.
// Optional macro MFC_TIMEOUT_EN adds a 4-bit memory wait counter that
// moves the FSM to a sticky FAULT state when MFC never arrives.
// All outputs are registered: they are decoded from the next state and
// loaded together with the state, so they always match STATE.
module dp_control_fsm (
  input  logic               Clk,
  input  logic               Reset,
  dp_control_fsm_if.master   bus
);

  typedef enum logic [3:0] {
    ST_RST0   = 4'd0,
    ST_RST1   = 4'd1,
    ST_FETCH0 = 4'd2,
    ST_FETCH1 = 4'd3,
    ST_FETCH2 = 4'd4,
    ST_DECODE = 4'd5,
    ST_ALU    = 4'd6,
    ST_BR_T   = 4'd7,
    ST_PCUPD  = 4'd8,
    ST_ANNUL  = 4'd9,
    ST_FAULT  = 4'd15
  } state_e;

  typedef struct packed {
    logic       ire;
    logic       mdre;
    logic       pce;
    logic       npce;
    logic       mare;
    logic       rfe;
    logic       clr_pc;
    logic       npc_clr;
    logic       ir_clr;
    logic       tq_clr;
    logic       mfa;
    logic       alue;
    logic       npc_add;
    logic       npc_addsel;
    logic       baux;
    logic       mop_sel;
    logic       disp_sel;
    logic       ra_sel;
    logic       aop_sel;
    logic [1:0] npc_sel;
    logic [1:0] mar_sel;
    logic [1:0] mdr_sel;
    logic [1:0] alu_sel;
    logic [1:0] cin_sel;
    logic [1:0] rc_sel;
    logic [5:0] op1;
    logic       fault;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

`ifdef MFC_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

  // Control word for a given state; everything not listed is at idle.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c            = '0;
    c.ire        = 1'b1;
    c.mdre       = 1'b1;
    c.pce        = 1'b1;
    c.npce       = 1'b1;
    c.mare       = 1'b1;
    c.rfe        = 1'b1;
    c.clr_pc     = 1'b1;
    c.npc_clr    = 1'b1;
    c.ir_clr     = 1'b1;
    c.tq_clr     = 1'b1;
    c.mop_sel    = 1'b1;
    c.op1        = 6'h08;
    case (s)
      ST_RST0: begin
        c.clr_pc  = 1'b0;
        c.npc_clr = 1'b0;
        c.ir_clr  = 1'b0;
        c.tq_clr  = 1'b0;
      end
      ST_RST1: begin
        c.npc_sel    = 2'd0;
        c.npc_addsel = 1'b0;
        c.npc_add    = 1'b1;
        c.npce       = 1'b0;
      end
      ST_FETCH0: begin
        c.mar_sel = 2'd0;
        c.mare    = 1'b0;
      end
      ST_FETCH1: begin
        c.mdr_sel = 2'd0;
        c.mdre    = 1'b0;
        c.mfa     = 1'b1;
      end
      ST_FETCH2: begin
        c.ire = 1'b0;
        c.mfa = 1'b0;
      end
      ST_ALU: begin
        c.cin_sel = 2'd2;
        c.ra_sel  = 1'b0;
        c.rc_sel  = 2'd0;
        c.aop_sel = 1'b0;
        c.alu_sel = 2'd0;
        c.rfe     = 1'b0;
        c.alue    = 1'b1;
      end
      ST_BR_T: begin
        c.pce      = 1'b0;
        c.npce     = 1'b0;
        c.npc_sel  = 2'd2;
        c.disp_sel = 1'b0;
        c.baux     = 1'b1;
      end
      ST_PCUPD, ST_ANNUL: begin
        c.pce        = 1'b0;
        c.npce       = 1'b0;
        c.npc_sel    = 2'd0;
        c.npc_addsel = 1'b0;
        c.npc_add    = 1'b1;
      end
`ifdef MFC_TIMEOUT_EN
      ST_FAULT: c.fault = 1'b1;
`endif
      default: ;
    endcase
    return c;
  endfunction

  // Next-state selection, wait-counter update and next control word.
  always_comb begin
    state_d = state_q;
`ifdef MFC_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      ST_RST0:   state_d = ST_RST1;
      ST_RST1:   state_d = ST_FETCH0;
      ST_FETCH0: begin
        state_d = ST_FETCH1;
`ifdef MFC_TIMEOUT_EN
        wait_cnt_d = 4'd0;
`endif
      end
      ST_FETCH1: begin
        if (bus.MFC) begin
          state_d = ST_FETCH2;
        end else begin
`ifdef MFC_TIMEOUT_EN
          if (wait_cnt_q == 4'd15) begin
            state_d = ST_FAULT;
          end else begin
            state_d    = ST_FETCH1;
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
`else
          state_d = ST_FETCH1;
`endif
        end
      end
      ST_FETCH2: state_d = ST_DECODE;
      ST_DECODE: begin
        if (bus.IR[31:30] == 2'b10) begin
          state_d = ST_ALU;
        end else if ((bus.IR[31:30] == 2'b00) && (bus.IR[24:22] == 3'b010)) begin
          if (bus.COND)        state_d = ST_BR_T;
          else if (bus.IR[29]) state_d = ST_ANNUL;
          else                 state_d = ST_PCUPD;
        end else begin
          state_d = ST_PCUPD;
        end
      end
      ST_ALU:    state_d = ST_PCUPD;
      ST_BR_T:   state_d = ST_FETCH0;
      ST_PCUPD:  state_d = ST_FETCH0;
      ST_ANNUL:  state_d = ST_PCUPD;
`ifdef MFC_TIMEOUT_EN
      ST_FAULT:  state_d = ST_FAULT;
`endif
      default:   state_d = ST_RST0;
    endcase
    ctrl_d = decode_ctrl(state_d);
  end

  // State, counter and registered control outputs; reset forces RST0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RST0;
      ctrl_q  <= decode_ctrl(ST_RST0);
`ifdef MFC_TIMEOUT_EN
      wait_cnt_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
`ifdef MFC_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign bus.IRE        = ctrl_q.ire;
  assign bus.MDRE       = ctrl_q.mdre;
  assign bus.PCE        = ctrl_q.pce;
  assign bus.nPCE       = ctrl_q.npce;
  assign bus.MARE       = ctrl_q.mare;
  assign bus.RFE        = ctrl_q.rfe;
  assign bus.ClrPC      = ctrl_q.clr_pc;
  assign bus.nPCClr     = ctrl_q.npc_clr;
  assign bus.IRClr      = ctrl_q.ir_clr;
  assign bus.tQClr      = ctrl_q.tq_clr;
  assign bus.MFA        = ctrl_q.mfa;
  assign bus.ALUE       = ctrl_q.alue;
  assign bus.nPC_ADD    = ctrl_q.npc_add;
  assign bus.nPC_ADDSEL = ctrl_q.npc_addsel;
  assign bus.BAUX       = ctrl_q.baux;
  assign bus.MOP_SEL    = ctrl_q.mop_sel;
  assign bus.DISP_SEL   = ctrl_q.disp_sel;
  assign bus.RA_SEL     = ctrl_q.ra_sel;
  assign bus.AOP_SEL    = ctrl_q.aop_sel;
  assign bus.nPC_SEL    = ctrl_q.npc_sel;
  assign bus.MAR_SEL    = ctrl_q.mar_sel;
  assign bus.MDR_SEL    = ctrl_q.mdr_sel;
  assign bus.ALU_SEL    = ctrl_q.alu_sel;
  assign bus.CIN_SEL    = ctrl_q.cin_sel;
  assign bus.RC_SEL     = ctrl_q.rc_sel;
  assign bus.OP1        = ctrl_q.op1;
  assign bus.FAULT      = ctrl_q.fault;
  assign bus.STATE      = state_q;

endmodule

// File: tb/tb_dp_control_fsm.sv
// Self-checking bench for dp_control_fsm. Each stimulus step pushes the
// expected state/output vector to a scoreboard; a monitor pops and
// compares one entry 1 time unit after every rising edge.
module tb_dp_control_fsm;

  logic Clk;
  logic Reset;

  dp_control_fsm_if bus ();

  dp_control_fsm dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [63:0] outs;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;

  // Free-running clock, period 10.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected control vector for a state, built from the state table.
  function automatic logic [63:0] expVec(input logic [3:0] st);
    logic ire, mdre, pce, npce, mare, rfe;
    logic clrPc, npcClr, irClr, tqClr;
    logic mfa, alue, npcAdd, npcAddsel, baux, mopSel, dispSel, raSel, aopSel;
    logic [1:0] npcSel, marSel, mdrSel, aluSel, cinSel, rcSel;
    logic [5:0] op1;
    logic fault;
    {ire, mdre, pce, npce, mare, rfe} = 6'b111111;
    {clrPc, npcClr, irClr, tqClr} = 4'b1111;
    {mfa, alue, npcAdd, npcAddsel, baux} = 5'b00000;
    mopSel = 1'b1;
    {dispSel, raSel, aopSel} = 3'b000;
    {npcSel, marSel, mdrSel, aluSel, cinSel, rcSel} = 12'h000;
    op1 = 6'h08;
    fault = 1'b0;
    case (st)
      4'd0: {clrPc, npcClr, irClr, tqClr} = 4'b0000;
      4'd1: begin npcAdd = 1'b1; npce = 1'b0; end
      4'd2: mare = 1'b0;
      4'd3: begin mdre = 1'b0; mfa = 1'b1; end
      4'd4: ire = 1'b0;
      4'd6: begin cinSel = 2'd2; rfe = 1'b0; alue = 1'b1; end
      4'd7: begin pce = 1'b0; npce = 1'b0; npcSel = 2'd2; baux = 1'b1; end
      4'd8, 4'd9: begin pce = 1'b0; npce = 1'b0; npcAdd = 1'b1; end
      4'd15: fault = 1'b1;
      default: ;
    endcase
    return {26'd0, ire, mdre, pce, npce, mare, rfe, clrPc, npcClr, irClr, tqClr,
            mfa, alue, npcAdd, npcAddsel, baux, mopSel, dispSel, raSel, aopSel,
            npcSel, marSel, mdrSel, aluSel, cinSel, rcSel, op1, fault};
  endfunction

  // Observed control vector, same field order as expVec.
  function automatic logic [63:0] actVec();
    return {26'd0, bus.IRE, bus.MDRE, bus.PCE, bus.nPCE, bus.MARE, bus.RFE,
            bus.ClrPC, bus.nPCClr, bus.IRClr, bus.tQClr,
            bus.MFA, bus.ALUE, bus.nPC_ADD, bus.nPC_ADDSEL, bus.BAUX, bus.MOP_SEL,
            bus.DISP_SEL, bus.RA_SEL, bus.AOP_SEL,
            bus.nPC_SEL, bus.MAR_SEL, bus.MDR_SEL, bus.ALU_SEL, bus.CIN_SEL, bus.RC_SEL,
            bus.OP1, bus.FAULT};
  endfunction

  // Counts one comparison and reports it if it differs.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives inputs for one cycle (sampled at the next rising edge) and
  // queues the state expected right after that edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic mfc,
                               input logic cond, input logic [31:0] ir, input logic [3:0] expState);
    exp_t e;
    @(negedge Clk);
    Reset    = rst;
    bus.MFC  = mfc;
    bus.COND = cond;
    bus.IR   = ir;
    e.tag  = tag;
    e.st   = expState;
    e.outs = expVec(expState);
    expQ.push_back(e);
  endtask

  // Scoreboard monitor: compare after each edge whenever an entry is pending.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.tag, "_state"}, {60'd0, bus.STATE}, {60'd0, e.st});
      checkOutput({e.tag, "_outs"}, actVec(), e.outs);
    end
  end

  // Runs a fetch from FETCH0 with nWait FETCH1 cycles, ending in DECODE.
  task automatic fetchToDecode(input string tag, input logic [31:0] ir, input logic cond, input int nWait);
    applyStimulus({tag, "_f1"}, 1'b0, 1'b0, cond, ir, 4'd3);
    for (int i = 1; i < nWait; i++) applyStimulus({tag, "_wait"}, 1'b0, 1'b0, cond, ir, 4'd3);
    applyStimulus({tag, "_f2"}, 1'b0, 1'b1, cond, ir, 4'd4);
    applyStimulus({tag, "_dec"}, 1'b0, 1'b0, cond, ir, 4'd5);
  endtask

  initial begin
    Reset    = 1'b1;
    bus.MFC  = 1'b0;
    bus.COND = 1'b0;
    bus.IR   = 32'h0;

    // Reset sequence: two reset cycles, then RST1, FETCH0.
    applyStimulus("rst_a", 1'b1, 1'b0, 1'b0, 32'h0, 4'd0);
    applyStimulus("rst_b", 1'b1, 1'b0, 1'b0, 32'h0, 4'd0);
    applyStimulus("rst1",  1'b0, 1'b0, 1'b0, 32'h0, 4'd1);
    applyStimulus("fetch0", 1'b0, 1'b0, 1'b0, 32'h0, 4'd2);

    // ALU instruction with a 3-cycle memory wait.
    fetchToDecode("alu", 32'hA2044012, 1'b0, 3);
    applyStimulus("alu_ex",  1'b0, 1'b0, 1'b0, 32'hA2044012, 4'd6);
    applyStimulus("alu_pcu", 1'b0, 1'b0, 1'b0, 32'hA2044012, 4'd8);
    applyStimulus("alu_f0",  1'b0, 1'b0, 1'b0, 32'hA2044012, 4'd2);

    // Taken branch.
    fetchToDecode("brt", 32'h12800005, 1'b1, 1);
    applyStimulus("brt_br", 1'b0, 1'b0, 1'b1, 32'h12800005, 4'd7);
    applyStimulus("brt_f0", 1'b0, 1'b0, 1'b1, 32'h12800005, 4'd2);

    // Annulled branch: ANNUL, PCUPD, FETCH0.
    fetchToDecode("ann", 32'h32800005, 1'b0, 2);
    applyStimulus("ann_an",  1'b0, 1'b0, 1'b0, 32'h32800005, 4'd9);
    applyStimulus("ann_pcu", 1'b0, 1'b0, 1'b0, 32'h32800005, 4'd8);
    applyStimulus("ann_f0",  1'b0, 1'b0, 1'b0, 32'h32800005, 4'd2);

    // Untaken branch without annul, and a non-ALU, non-branch instruction.
    fetchToDecode("bnt", 32'h12800005, 1'b0, 1);
    applyStimulus("bnt_pcu", 1'b0, 1'b0, 1'b0, 32'h12800005, 4'd8);
    applyStimulus("bnt_f0",  1'b0, 1'b0, 1'b0, 32'h12800005, 4'd2);
    fetchToDecode("oth", 32'h40000000, 1'b1, 1);
    applyStimulus("oth_pcu", 1'b0, 1'b0, 1'b1, 32'h40000000, 4'd8);
    applyStimulus("oth_f0",  1'b0, 1'b0, 1'b1, 32'h40000000, 4'd2);

    // Reset in the middle of FETCH1.
    applyStimulus("mid_f1a", 1'b0, 1'b0, 1'b0, 32'h0, 4'd3);
    applyStimulus("mid_f1b", 1'b0, 1'b0, 1'b0, 32'h0, 4'd3);
    applyStimulus("mid_rst", 1'b1, 1'b0, 1'b0, 32'h0, 4'd0);
    applyStimulus("mid_r1",  1'b0, 1'b0, 1'b0, 32'h0, 4'd1);
    applyStimulus("mid_f0",  1'b0, 1'b0, 1'b0, 32'h0, 4'd2);

`ifdef MFC_TIMEOUT_EN
    // Timeout: 16 FETCH1 cycles without MFC, then sticky FAULT.
    applyStimulus("to_f1", 1'b0, 1'b0, 1'b0, 32'h0, 4'd3);
    for (int i = 0; i < 15; i++) applyStimulus("to_wait", 1'b0, 1'b0, 1'b0, 32'h0, 4'd3);
    applyStimulus("to_fault", 1'b0, 1'b0, 1'b0, 32'h0, 4'd15);
    applyStimulus("to_hold1", 1'b0, 1'b1, 1'b0, 32'h0, 4'd15);
    applyStimulus("to_hold2", 1'b0, 1'b0, 1'b0, 32'h0, 4'd15);
    applyStimulus("to_rst", 1'b1, 1'b0, 1'b0, 32'h0, 4'd0);
    applyStimulus("to_r1",  1'b0, 1'b0, 1'b0, 32'h0, 4'd1);
    applyStimulus("to_f0",  1'b0, 1'b0, 1'b0, 32'h0, 4'd2);
    // MFC on the 16th FETCH1 cycle wins over the timeout.
    fetchToDecode("late", 32'hA2044012, 1'b0, 16);
    applyStimulus("late_alu", 1'b0, 1'b0, 1'b0, 32'hA2044012, 4'd6);
    applyStimulus("late_pcu", 1'b0, 1'b0, 1'b0, 32'hA2044012, 4'd8);
    applyStimulus("late_f0",  1'b0, 1'b0, 1'b0, 32'hA2044012, 4'd2);
`else
    // Without the timeout, FETCH1 waits indefinitely with FAULT low.
    applyStimulus("nto_f1", 1'b0, 1'b0, 1'b0, 32'h0, 4'd3);
    for (int i = 0; i < 20; i++) applyStimulus("nto_wait", 1'b0, 1'b0, 1'b0, 32'h0, 4'd3);
    applyStimulus("nto_f2",  1'b0, 1'b1, 1'b0, 32'h0, 4'd4);
    applyStimulus("nto_dec", 1'b0, 1'b0, 1'b0, 32'h0, 4'd5);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge Clk);
    #2;
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dp_control_fsm.md
DP_CONTROL_FSM -- requirements
Module: dp_control_fsm

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port `Clk`: input, 1 bit; all state updates occur on the rising edge.
REQ-003 Port `Reset`: input, 1 bit; synchronous, active-high.
REQ-004 Port `IR`: input, 32 bits; current instruction register contents from the datapath.
REQ-005 Port `MFC`: input, 1 bit; memory function complete.
REQ-006 Port `COND`: input, 1 bit; branch condition evaluated true.
REQ-007 Ports `IRE`, `MDRE`, `PCE`, `nPCE`, `MARE`, `RFE`: output, 1 bit each; register load enables, active-low.
REQ-008 Ports `ClrPC`, `nPCClr`, `IRClr`, `tQClr`: output, 1 bit each; clears, active-low.
REQ-009 Ports `MFA`, `ALUE`, `nPC_ADD`, `nPC_ADDSEL`, `BAUX`, `MOP_SEL`, `DISP_SEL`, `RA_SEL`, `AOP_SEL`: output, 1 bit each; datapath controls, active-high.
REQ-010 Ports `nPC_SEL`, `MAR_SEL`, `MDR_SEL`, `ALU_SEL`, `CIN_SEL`, `RC_SEL`: output, 2 bits each; datapath mux selects.
REQ-011 Port `OP1`: output, 6 bits; memory opcode.
REQ-012 Port `FAULT`: output, 1 bit; memory timeout flag.
REQ-013 Port `STATE`: output, 4 bits; current state encoding, for debug.

Function
REQ-014 Outputs SHALL be Moore, decoded from the registered state only.
- Idle value of every output: active-low enables and clears = 1; `MFA`, `ALUE`, `nPC_ADD`, `BAUX` = 0; `OP1` = 6'h08; `MOP_SEL` = 1; all selects = 0.

REQ-015 States and encodings SHALL be: RST0=0, RST1=1, FETCH0=2, FETCH1=3, FETCH2=4, DECODE=5, ALU=6, BR_T=7, PCUPD=8, ANNUL=9, FAULT=15.

REQ-016 RST0 SHALL drive `ClrPC`, `nPCClr`, `IRClr` and `tQClr` = 0, and always go to RST1.
REQ-017 RST1 SHALL drive `nPC_SEL`=0, `nPC_ADDSEL`=0, `nPC_ADD`=1 and `nPCE`=0, so that nPC = 4; it then goes to FETCH0.
REQ-018 FETCH0 SHALL drive `MAR_SEL`=0 (PC) and `MARE`=0, and go to FETCH1.
REQ-019 FETCH1 SHALL drive `MDR_SEL`=0, `MDRE`=0 and `MFA`=1.
- It remains in FETCH1 while `MFC`=0.
- It goes to FETCH2 in the cycle after `MFC`=1 is sampled.
REQ-020 FETCH2 SHALL drive `IRE`=0 with `MFA`=0, and go to DECODE.
REQ-021 DECODE SHALL drive idle outputs and choose the next state as follows:
- `IR[31:30]`=2'b10: go to ALU.
- `IR[31:30]`=2'b00 and `IR[24:22]`=3'b010 (Bicc), with `COND`=1: go to BR_T.
- Bicc with `COND`=0 and `IR[29]`=1: go to ANNUL.
- Bicc with `COND`=0 and `IR[29]`=0: go to PCUPD.
- Any other instruction: go to PCUPD.
REQ-022 ALU SHALL drive `CIN_SEL`=2, `RA_SEL`=0, `RC_SEL`=0, `AOP_SEL`=0, `ALU_SEL`=0, `RFE`=0 and `ALUE`=1, and go to PCUPD.
REQ-023 BR_T SHALL drive `PCE`=0, `nPCE`=0, `nPC_SEL`=2, `DISP_SEL`=0 and `BAUX`=1, and go to FETCH0.
- Effect: PC ← nPC and nPC ← PC + 4·disp22, both on the same edge.
REQ-024 PCUPD SHALL drive `PCE`=0, `nPCE`=0, `nPC_SEL`=0, `nPC_ADDSEL`=0 and `nPC_ADD`=1, and go to FETCH0.
- Effect: PC ← nPC and nPC ← nPC + 4.
REQ-025 ANNUL SHALL drive the same outputs as PCUPD and go to PCUPD.
- Effect: the delay slot is skipped and the net advance is 8 bytes.
REQ-026 FAULT SHALL drive idle outputs with `FAULT`=1, and SHALL hold until `Reset`.
REQ-027 Undefined state encodings SHALL go to RST0 on the next edge.

Reset
REQ-028 With `Reset`=1 at a rising edge, the state SHALL become RST0 and the wait counter SHALL clear to 0, regardless of the current state.
- This includes mid-FETCH1: `MFA` is 0 from the following cycle.
REQ-029 While in RST0, every output SHALL equal its idle value except the four clears, which are 0.
- `FAULT`=0 and `STATE`=0.
REQ-030 Release of `Reset` SHALL be followed by RST0, then RST1, then FETCH0 on consecutive cycles.

Configuration
REQ-031 Macro `MFC_TIMEOUT_EN` SHALL select the memory timeout behaviour.
- Defined: a 4-bit wait counter is included. It clears on entry to FETCH1 and increments each FETCH1 cycle with `MFC`=0. When it reaches 15 with `MFC` still 0, the next state is FAULT. `MFC`=1 in that same cycle takes precedence and the next state is FETCH2.
- Undefined: there is no counter, FETCH1 waits indefinitely, and `FAULT` is constant 0.

Verification
REQ-032 Reset sequence: hold `Reset`=1 for 2 cycles, then release → `STATE` shows 0, 1, 2, with `ClrPC`=0 only in state 0 and `nPC_ADD`=1 only in state 1.
REQ-033 Fetch, ALU path: `MFC` rises after 3 FETCH1 cycles, `IR`=32'hA2044012 → `MFA`=1 for exactly 3 cycles, then `IRE`=0 for 1 cycle, then DECODE, ALU (`RFE`=0, `ALUE`=1), PCUPD, FETCH0.
REQ-034 Taken branch: `IR`=32'h12800005 with `COND`=1 → DECODE, BR_T (`nPC_SEL`=2, `BAUX`=1, `PCE`=0, `nPCE`=0), FETCH0.
REQ-035 Annulled branch: `IR`=32'h32800005 (a=1) with `COND`=0 → ANNUL, PCUPD, FETCH0, with `PCE`=0 in both update states.
REQ-036 Timeout (macro defined): `MFC` held at 0 → `FAULT`=1 and `STATE`=15 after 16 FETCH1 cycles, holding until `Reset`. With `MFC`=1 on the 16th cycle → FETCH2 and `FAULT`=0.
REQ-037 Mid-fetch reset: `Reset`=1 during FETCH1 with `MFA`=1 → the next cycle shows `STATE`=0 and `MFA`=0.
